// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: routes decoded ops to the fast pipe or the shared
// iterative DIV/SQRT unit, tracks the single in-flight long op, raises
// hazard stalls and arbitrates the shared FPR write port.

package fpu_issue_pkg;
   typedef enum logic [3:0] {
      FPU_OP_ADD     = 4'd0,
      FPU_OP_SUB     = 4'd1,
      FPU_OP_MUL     = 4'd2,
      FPU_OP_DIV     = 4'd3,
      FPU_OP_SQRT    = 4'd4,
      FPU_OP_CVT     = 4'd5,
      FPU_OP_MFC     = 4'd6,
      FPU_OP_MTC     = 4'd7,
      FPU_OP_CFC     = 4'd8,
      FPU_OP_CTC     = 4'd9,
      FPU_OP_COND    = 4'd10,
      FPU_OP_INVALID = 4'd11
   } FPUOper_t;
endpackage

module fpu_issue_ctrl
   import fpu_issue_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  FPUOper_t   id_op,
   input  logic [4:0] id_raddr1,
   input  logic [4:0] id_raddr2,
   input  logic       id_we,
   input  logic [4:0] id_waddr,
   input  logic       ex_ready,
   input  logic       flush,
   input  logic       long_done,
   input  logic       fast_wb_valid,
   output logic       stall_o,
   output logic       issue_fast,
   output logic       issue_long,
   output logic [4:0] long_dst,
   output logic       long_ack,
   output logic       long_abort,
   output logic       busy
);

   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WB} state_t;

   state_t            state_q, state_d;
   logic              pend_v_q, pend_v_d;
   logic [4:0]        long_dst_q, long_dst_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              long_abort_q, long_abort_d;

   logic op_long, op_fcsr, in_flight;
   logic raw, waw, drain, hz, go;

   assign in_flight = (state_q != S_IDLE);
   assign op_long   = (id_op == FPU_OP_DIV) || (id_op == FPU_OP_SQRT);
   assign op_fcsr   = (id_op == FPU_OP_CFC) || (id_op == FPU_OP_CTC) ||
                      (id_op == FPU_OP_COND);

   // FPR0 is not special-cased, so unused source fields may stall conservatively
   assign raw   = pend_v_q && ((id_raddr1 == long_dst_q) || (id_raddr2 == long_dst_q));
   assign waw   = pend_v_q && id_we && (id_waddr == long_dst_q);
   assign drain = (wait_cnt_q == WAIT_MAX);
   assign hz    = id_valid && (raw || waw || drain || (in_flight && (op_long || op_fcsr)));

   assign go         = id_valid && !flush && !hz && ex_ready;
   assign issue_fast = go && !op_long;
   assign issue_long = go && op_long;
   assign stall_o    = !flush && id_valid && (hz || !ex_ready);

   // fast pipe always owns the write port when both want it
   assign long_ack   = !flush && long_done && in_flight && !fast_wb_valid;

   assign long_dst   = long_dst_q;
   assign long_abort = long_abort_q;
   assign busy       = in_flight;

   // next-state for FSM, scoreboard, starvation counter and abort pulse
   always_comb begin
      state_d      = state_q;
      pend_v_d     = pend_v_q;
      long_dst_d   = long_dst_q;
      wait_cnt_d   = wait_cnt_q;
      long_abort_d = flush && in_flight;

      unique case (state_q)
         S_IDLE:  if (issue_long) state_d = S_BUSY;
         S_BUSY:  if (long_ack) state_d = S_IDLE;
                  else if (long_done) state_d = S_WB;
         S_WB:    if (long_ack) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (flush || long_ack) begin
         pend_v_d   = 1'b0;
         wait_cnt_d = '0;
      end else begin
         if (long_done && !drain) wait_cnt_d = wait_cnt_q + 1'b1;
         if (issue_long) begin
            pend_v_d   = id_we;
            long_dst_d = id_waddr;
         end
      end

      if (flush) state_d = S_IDLE;
   end

   // state registers; rst wins over flush and any in-flight op
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pend_v_q     <= 1'b0;
         long_dst_q   <= 5'd0;
         wait_cnt_q   <= '0;
         long_abort_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_v_q     <= pend_v_d;
         long_dst_q   <= long_dst_d;
         wait_cnt_q   <= wait_cnt_d;
         long_abort_q <= long_abort_d;
      end
   end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed cycle table, hand sequences for
// starvation/flush corners, then random traffic against a reference model.
module tb_fpu_issue_ctrl;
   import fpu_issue_pkg::*;

   localparam int MAXW = 4;

   logic       clk = 1'b0;
   logic       rst, id_valid, id_we, ex_ready, flush, long_done, fast_wb_valid;
   FPUOper_t   id_op;
   logic [4:0] id_raddr1, id_raddr2, id_waddr;
   logic       stall_o, issue_fast, issue_long, long_ack, long_abort, busy;
   logic [4:0] long_dst;

   int checks = 0;
   int errors = 0;

   fpu_issue_ctrl #(.MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
      .id_raddr1(id_raddr1), .id_raddr2(id_raddr2), .id_we(id_we),
      .id_waddr(id_waddr), .ex_ready(ex_ready), .flush(flush),
      .long_done(long_done), .fast_wb_valid(fast_wb_valid),
      .stall_o(stall_o), .issue_fast(issue_fast), .issue_long(issue_long),
      .long_dst(long_dst), .long_ack(long_ack), .long_abort(long_abort),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // one cycle of stimulus plus expected outputs
   // exp = {stall, issue_fast, issue_long, long_ack, long_abort, busy}
   typedef struct {
      logic       rst, v;
      FPUOper_t   op;
      logic [4:0] r1, r2;
      logic       we;
      logic [4:0] wa;
      logic       ex, fl, ld, fwb;
      logic [5:0] exp;
      logic [4:0] dst;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic v, input FPUOper_t op,
                               input int r1, input int r2, input logic we, input int wa,
                               input logic ex, input logic fl, input logic ld,
                               input logic fwb, input logic [5:0] exp, input int dst);
      vec_t t;
      t.rst = r; t.v = v; t.op = op; t.r1 = 5'(r1); t.r2 = 5'(r2); t.we = we;
      t.wa = 5'(wa); t.ex = ex; t.fl = fl; t.ld = ld; t.fwb = fwb;
      t.exp = exp; t.dst = 5'(dst);
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      rst = t.rst; id_valid = t.v; id_op = t.op; id_raddr1 = t.r1;
      id_raddr2 = t.r2; id_we = t.we; id_waddr = t.wa; ex_ready = t.ex;
      flush = t.fl; long_done = t.ld; fast_wb_valid = t.fwb;
   endtask

   task automatic check_out(input string tag, input logic [5:0] exp, input logic [4:0] dst);
      chk({tag, " stall_o"},    32'(stall_o),    32'(exp[5]));
      chk({tag, " issue_fast"}, 32'(issue_fast), 32'(exp[4]));
      chk({tag, " issue_long"}, 32'(issue_long), 32'(exp[3]));
      chk({tag, " long_ack"},   32'(long_ack),   32'(exp[2]));
      chk({tag, " long_abort"}, 32'(long_abort), 32'(exp[1]));
      chk({tag, " busy"},       32'(busy),       32'(exp[0]));
      chk({tag, " long_dst"},   32'(long_dst),   32'(dst));
      if (long_ack && fast_wb_valid) chk({tag, " port_conflict"}, 32'd1, 32'd0);
   endtask

   task automatic apply(input string tag, input vec_t t);
      @(negedge clk);
      drive(t);
      #1 check_out(tag, t.exp, t.dst);
   endtask

   vec_t tbl[$];

   // reference model state, kept as plain facts rather than FSM states
   bit m_inflight, m_pend, m_abort;
   int m_dst, m_wait;
   bit u_busy;
   int u_cnt;

   initial begin
      drive(mk(1, 0, FPU_OP_ADD, 0, 0, 0, 0, 1, 0, 0, 0, 6'b0, 0));
      repeat (2) @(posedge clk);

      //          rst v  op            r1 r2 we wa ex fl ld fwb  exp        dst
      tbl.push_back(mk(1, 0, FPU_OP_ADD,  0, 0, 0, 0, 1, 0, 0, 0, 6'b000000, 0));
      tbl.push_back(mk(0, 1, FPU_OP_DIV,  4, 6, 1, 2, 1, 0, 0, 0, 6'b001000, 0));
      tbl.push_back(mk(0, 1, FPU_OP_ADD,  2, 3, 1, 8, 1, 0, 0, 0, 6'b100001, 2));
      tbl.push_back(mk(0, 1, FPU_OP_ADD,  2, 3, 1, 8, 1, 0, 0, 0, 6'b100001, 2));
      tbl.push_back(mk(0, 1, FPU_OP_ADD,  2, 3, 1, 8, 1, 0, 1, 0, 6'b100101, 2));
      tbl.push_back(mk(0, 1, FPU_OP_ADD,  2, 3, 1, 8, 1, 0, 0, 0, 6'b010000, 2));
      tbl.push_back(mk(0, 1, FPU_OP_DIV,  4, 6, 1, 2, 1, 0, 0, 0, 6'b001000, 2));
      tbl.push_back(mk(0, 1, FPU_OP_SQRT, 7, 7, 1, 5, 1, 0, 0, 0, 6'b100001, 2));
      tbl.push_back(mk(0, 1, FPU_OP_CFC,  9, 9, 0, 0, 1, 0, 0, 0, 6'b100001, 2));
      tbl.push_back(mk(0, 1, FPU_OP_MTC,  0, 0, 1, 2, 1, 0, 0, 0, 6'b100001, 2));
      tbl.push_back(mk(0, 1, FPU_OP_MUL, 11,12, 1,10, 1, 0, 0, 0, 6'b010001, 2));
      tbl.push_back(mk(0, 1, FPU_OP_SQRT, 7, 7, 1, 5, 1, 0, 1, 0, 6'b100101, 2));
      tbl.push_back(mk(0, 1, FPU_OP_SQRT, 7, 7, 1, 5, 1, 0, 0, 0, 6'b001000, 2));
      tbl.push_back(mk(0, 0, FPU_OP_ADD,  0, 0, 0, 0, 1, 1, 0, 0, 6'b000001, 5));
      tbl.push_back(mk(0, 0, FPU_OP_ADD,  0, 0, 0, 0, 1, 0, 0, 0, 6'b000010, 5));
      tbl.push_back(mk(0, 1, FPU_OP_ADD,  5, 5, 1, 8, 1, 0, 0, 0, 6'b010000, 5));
      tbl.push_back(mk(0, 1, FPU_OP_MUL,  1, 3, 1, 9, 0, 0, 0, 0, 6'b100000, 5));
      tbl.push_back(mk(0, 1, FPU_OP_MUL,  1, 3, 1, 9, 1, 0, 0, 0, 6'b010000, 5));
      tbl.push_back(mk(0, 1, FPU_OP_DIV,  1, 1, 1, 3, 1, 0, 0, 0, 6'b001000, 5));
      tbl.push_back(mk(0, 0, FPU_OP_ADD,  0, 0, 0, 0, 1, 1, 1, 0, 6'b000001, 3));
      tbl.push_back(mk(0, 0, FPU_OP_ADD,  0, 0, 0, 0, 1, 0, 0, 0, 6'b000010, 3));
      tbl.push_back(mk(0, 1, FPU_OP_ADD,  1, 1, 1, 8, 1, 1, 0, 0, 6'b000000, 3));
      tbl.push_back(mk(0, 0, FPU_OP_ADD,  0, 0, 0, 0, 1, 0, 0, 0, 6'b000000, 3));

      foreach (tbl[i]) apply($sformatf("row%0d", i), tbl[i]);

      // starvation: fast pipe holds the port while the long result waits
      apply("starve_issue", mk(0, 1, FPU_OP_DIV, 4, 6, 1, 2, 1, 0, 0, 0, 6'b001000, 3));
      for (int k = 0; k < MAXW; k++)
         apply($sformatf("starve_lose%0d", k),
               mk(0, 1, FPU_OP_MUL, 11, 12, 1, 10, 1, 0, 1, 1, 6'b010001, 2));
      apply("starve_drain0", mk(0, 1, FPU_OP_MUL, 11, 12, 1, 10, 1, 0, 1, 1, 6'b100001, 2));
      apply("starve_drain1", mk(0, 1, FPU_OP_MUL, 11, 12, 1, 10, 1, 0, 1, 1, 6'b100001, 2));
      apply("starve_ack",    mk(0, 1, FPU_OP_MUL, 11, 12, 1, 10, 1, 0, 1, 0, 6'b100101, 2));
      apply("starve_after",  mk(0, 1, FPU_OP_MUL, 11, 12, 1, 10, 1, 0, 0, 0, 6'b010000, 2));

      // random traffic against the reference model
      @(negedge clk);
      drive(mk(1, 0, FPU_OP_ADD, 0, 0, 0, 0, 1, 0, 0, 0, 6'b0, 0));
      m_inflight = 0; m_pend = 0; m_abort = 0; m_dst = 0; m_wait = 0;
      u_busy = 0; u_cnt = 0;
      fast_wb_valid = 0;

      for (int c = 0; c < 3000; c++) begin
         bit r, v, we, ex, fl, ld, fwb, lng, fcsr, hz, go;
         bit e_stall, e_if, e_il, e_ack;
         int r1, r2, wa;
         FPUOper_t op;
         @(negedge clk);
         r   = ($urandom_range(0, 149) == 0);
         fl  = ($urandom_range(0, 24) == 0);
         v   = ($urandom_range(0, 3) != 0);
         ex  = ($urandom_range(0, 6) != 0);
         we  = $urandom_range(0, 1);
         op  = FPUOper_t'(4'($urandom_range(0, 11)));
         r1  = $urandom_range(0, 7);
         r2  = $urandom_range(0, 7);
         wa  = $urandom_range(0, 7);
         fwb = ($urandom_range(0, 9) < 3) ? !fast_wb_valid : fast_wb_valid;
         ld  = u_busy && (u_cnt == 0);

         lng  = (op == FPU_OP_DIV) || (op == FPU_OP_SQRT);
         fcsr = (op == FPU_OP_CFC) || (op == FPU_OP_CTC) || (op == FPU_OP_COND);
         hz   = (m_pend && (r1 == m_dst || r2 == m_dst)) ||
                (m_pend && we && wa == m_dst) ||
                (m_inflight && (lng || fcsr)) ||
                (m_wait == MAXW);
         e_stall = !fl && v && (hz || !ex);
         go      = v && !fl && !hz && ex;
         e_if    = go && !lng;
         e_il    = go && lng;
         e_ack   = !fl && ld && m_inflight && !fwb;

         drive(mk(r, v, op, r1, r2, we, wa, ex, fl, ld, fwb, 6'b0, 0));
         #1 check_out($sformatf("rnd%0d", c),
                      {e_stall, e_if, e_il, e_ack, m_abort, m_inflight}, 5'(m_dst));

         if (r) begin
            m_inflight = 0; m_pend = 0; m_abort = 0; m_dst = 0; m_wait = 0;
            u_busy = 0;
         end else begin
            m_abort = fl && m_inflight;
            if (fl || e_ack) begin
               m_inflight = 0; m_pend = 0; m_wait = 0; u_busy = 0;
            end else begin
               if (ld && m_wait < MAXW) m_wait++;
               if (u_busy && u_cnt > 0) u_cnt--;
            end
            if (e_il) begin
               m_inflight = 1; m_pend = we; m_dst = wa;
               u_busy = 1; u_cnt = $urandom_range(0, 5);
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Issue controller between the FPU decoder and the FPU execution resources. It sends each decoded FPU op either to the single-cycle FPU pipe or to the shared iterative DIV/SQRT unit. It tracks the single in-flight long op with a one-entry scoreboard, stalls the front end on hazards, and arbitrates the single FPR write port between the fast pipe and the long unit.

Parameters:
MAX_WAIT, 4, maximum number of cycles a completed long result may lose write-port arbitration before fast issue is blocked to drain the pipe.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
id_valid  in  1  decoded FPU op present
id_op  in  FPUOper_t  decoded op
id_raddr1  in  5  FPR source 1
id_raddr2  in  5  FPR source 2
id_we  in  1  op writes an FPR
id_waddr  in  5  FPR destination
ex_ready  in  1  downstream stage accepts an op this cycle
flush  in  1  pipeline flush (exception/redirect)
long_done  in  1  iterative unit result ready; level-held until long_ack
fast_wb_valid  in  1  fast pipe is writing the FPR port this cycle
stall_o  out  1  hold the decoder/ID stage
issue_fast  out  1  op accepted into the fast pipe this cycle
issue_long  out  1  start pulse to the iterative unit; the unit captures op and operands in the same cycle
long_dst  out  5  registered destination of the in-flight long op
long_ack  out  1  long result granted the FPR write port; the unit drops long_done next cycle
long_abort  out  1  one-cycle pulse that kills the in-flight long op
busy  out  1  long op in flight (state != IDLE)

Behaviour:
- Long ops: FPU_OP_DIV and FPU_OP_SQRT. Every other valid op, including FPU_OP_INVALID, is fast.
- FSM states: IDLE, BUSY (long op running), WB (long result ready, waiting for the write port).
- Transitions:
  - IDLE→BUSY on issue_long.
  - BUSY→WB on long_done without long_ack.
  - BUSY or WB→IDLE on long_ack.
  - Any state→IDLE on flush.
- Scoreboard: pend_v plus pend_dst (= long_dst). Set on issue_long when id_we is 1. Cleared on long_ack or flush. The clear takes effect in the next cycle; a dependent op stalls during the ack cycle.
- Hazard stall (hz), evaluated only when id_valid=1:
  - RAW: pend_v and (id_raddr1==pend_dst or id_raddr2==pend_dst). FPR 0 is compared like any other register, so the check is conservative for unused source fields.
  - WAW: pend_v, id_we, and id_waddr==pend_dst.
  - Structural: a long op while state!=IDLE.
  - FCSR: FPU_OP_CFC, FPU_OP_CTC or FPU_OP_COND while state!=IDLE.
  - Drain: wait_cnt==MAX_WAIT (blocks all issue).
- Combinational outputs:
  - stall_o = !flush and id_valid and (hz or !ex_ready).
  - issue_fast = id_valid and !flush and !hz and ex_ready and the op is fast.
  - issue_long = id_valid and !flush and !hz and ex_ready and the op is long.
  - Both issue outputs are 0-cycle latency, same cycle as ID.
- Write-port arbitration: long_ack = !flush and long_done and state∈{BUSY,WB} and !fast_wb_valid.
  - The fast pipe always wins a conflict.
  - long_ack must never be asserted together with fast_wb_valid.
- Starvation counter wait_cnt, width clog2(MAX_WAIT+1):
  - Increments each cycle long_done=1 and long_ack=0, saturating at MAX_WAIT.
  - Resets to 0 on long_ack, flush or rst.
  - At saturation the drain stall blocks new fast issue; fast_wb_valid drops once the pipe empties, and long_ack follows.
- Flush:
  - Suppresses all issue and long_ack in that cycle.
  - long_abort=1 if state was BUSY or WB.
  - Clears the scoreboard and wait_cnt.
  - A flush coincident with long_done discards the result.
- Reset (rst=1 at the edge): state IDLE, pend_v=0, long_dst=0, wait_cnt=0, long_abort=0. Combinational outputs evaluate to 0 when inputs are idle. rst overrides flush and a mid-operation long op; the iterative unit shares rst.
- long_abort is registered: it asserts the cycle after the flush cycle, for one cycle.

Test Plan:
- Reset with id_valid=0 → stall_o, issue_fast, issue_long, long_ack, long_abort, busy all 0; long_dst=0.
- DIV f2←f4,f6 with ex_ready=1 → issue_long=1 for exactly one cycle, long_dst=2, busy=1. ADD f8←f2,f3 → stall_o=1 until long_done; long_ack in cycle N; ADD issues in cycle N+1.
- DIV in flight plus SQRT f5←f7 → stall_o=1 (structural). After long_ack, SQRT issues the next cycle. CFC while busy → stalls. MTC writing f2 while pending → WAW stall.
- long_done=1 with fast_wb_valid=1 held, MAX_WAIT=4 → wait_cnt reaches 4 after 4 cycles and a valid fast op sees stall_o=1. Dropping fast_wb_valid → long_ack=1 that cycle, wait_cnt→0.
- flush during BUSY → long_abort pulse the cycle after flush, busy=0, pend_v=0. ADD reading f2 issues the next cycle without stall. flush coincident with long_done → long_ack stays 0.
- ex_ready=0 with a hazard-free MUL → stall_o=1, issue_fast=0. Raising ex_ready → issue_fast=1 the same cycle.
